hynoc_egress_port: RTL and testbench



---
 rtl/hynoc_egress_port.sv | 194 +++++++++++++++++++
 tb/tb_hynoc_egress_port.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hynoc_egress_port.sv
// HyNoC egress port: arbitrates the other ports' ingress requests, buffers the granted packet
// in a local FIFO and throttles the granted ingress. Define HYNOC_EGRESS_PORT_FIXED_PRIO_EN for fixed priority.
module hynoc_egress_port #(
    parameter int NB_PORTS        = 5,
    parameter int FLIT_WIDTH      = 33,
    parameter int LOG2_FIFO_DEPTH = 5,
    parameter int AFULL_MARGIN    = 5
) (
    input  logic                                  router_clk,
    input  logic                                  router_srst_n,
    input  logic [NB_PORTS-2:0]                   from_ingress_request,
    input  logic [NB_PORTS-2:0]                   from_ingress_write,
    input  logic [(NB_PORTS-1)*FLIT_WIDTH-1:0]    from_ingress_data,
    output logic [NB_PORTS-2:0]                   to_ingress_grant,
    output logic [NB_PORTS-2:0]                   to_ingress_afull,
    input  logic                                  ren,
    output logic [FLIT_WIDTH-1:0]                 rdata,
    output logic                                  rempty,
    output logic [LOG2_FIFO_DEPTH:0]              rlevel,
    output logic                                  overflow
);

    localparam int NB_SRC = NB_PORTS - 1;
    localparam int IDX_W  = (NB_SRC > 1) ? $clog2(NB_SRC) : 1;
    localparam int DEPTH  = 2 ** LOG2_FIFO_DEPTH;
    localparam int LVL_W  = LOG2_FIFO_DEPTH + 1;

    localparam logic [LVL_W-1:0] AFULL_THR = LVL_W'(DEPTH - AFULL_MARGIN);
    localparam logic [LVL_W-1:0] FULL_LVL  = LVL_W'(DEPTH);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [NB_SRC-1:0]     grant_q, grant_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NB_SRC-1:0]     afull_q, afull_d;
    logic [LVL_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [FLIT_WIDTH-1:0] rdata_q, rdata_d;
    logic                  overflow_q, overflow_d;
`ifndef HYNOC_EGRESS_PORT_FIXED_PRIO_EN
    logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
`endif

    logic [FLIT_WIDTH-1:0] fifo_mem [DEPTH];

    logic                  found;
    logic [IDX_W-1:0]      win_idx;
    logic                  wr_sel;
    logic [FLIT_WIDTH-1:0] sel_flit;
    logic                  sel_eop;
    logic                  push_req;
    logic                  push_ok;
    logic                  pop;
    logic [LVL_W-1:0]      level;
    logic                  fifo_empty;
    logic                  fifo_full;

    // Winner selection: lowest index, or first requester at/after the round-robin pointer.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
`ifdef HYNOC_EGRESS_PORT_FIXED_PRIO_EN
        for (int i = 0; i < NB_SRC; i++) begin
            if (!found && from_ingress_request[IDX_W'(i)]) begin
                found   = 1'b1;
                win_idx = IDX_W'(i);
            end
        end
`else
        for (int k = 0; k < NB_SRC; k++) begin
            logic [IDX_W-1:0] cand;
            cand = IDX_W'((int'(rr_ptr_q) + k) % NB_SRC);
            if (!found && from_ingress_request[cand]) begin
                found   = 1'b1;
                win_idx = cand;
            end
        end
`endif
    end

    always_comb begin
        wr_sel   = 1'b0;
        sel_flit = '0;
        for (int i = 0; i < NB_SRC; i++) begin
            if (IDX_W'(i) == idx_q) begin
                wr_sel   = from_ingress_write[i];
                sel_flit = from_ingress_data[i*FLIT_WIDTH +: FLIT_WIDTH];
            end
        end
        sel_eop = sel_flit[FLIT_WIDTH-1];
    end

    // A packet's EOP releases the grant even when the flit itself is dropped on a full FIFO.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        idx_d    = idx_q;
        push_req = 1'b0;
`ifndef HYNOC_EGRESS_PORT_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    idx_d            = win_idx;
                    state_d          = ST_GRANT;
                end
            end
            ST_GRANT: begin
                push_req = wr_sel;
                if (wr_sel && sel_eop) begin
                    grant_d = '0;
                    state_d = ST_IDLE;
`ifndef HYNOC_EGRESS_PORT_FIXED_PRIO_EN
                    rr_ptr_d = (idx_q == IDX_W'(NB_SRC - 1)) ? '0 : idx_q + IDX_W'(1);
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // A pop on a full FIFO frees the slot the simultaneous push lands in.
    always_comb begin
        level      = wr_ptr_q - rd_ptr_q;
        fifo_empty = (level == '0);
        fifo_full  = (level == FULL_LVL);
        pop        = ren && !fifo_empty;
        push_ok    = push_req && (!fifo_full || pop);

        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        rdata_d    = rdata_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + LVL_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + LVL_W'(1);
            rdata_d  = fifo_mem[rd_ptr_q[LOG2_FIFO_DEPTH-1:0]];
        end

        overflow_d = overflow_q || (push_req && fifo_full && !pop);
        afull_d    = (level >= AFULL_THR) ? grant_d : '0;
    end

    always_ff @(posedge router_clk) begin
        if (!router_srst_n) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            idx_q      <= '0;
            afull_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            rdata_q    <= '0;
            overflow_q <= 1'b0;
`ifndef HYNOC_EGRESS_PORT_FIXED_PRIO_EN
            rr_ptr_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            idx_q      <= idx_d;
            afull_q    <= afull_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            rdata_q    <= rdata_d;
            overflow_q <= overflow_d;
`ifndef HYNOC_EGRESS_PORT_FIXED_PRIO_EN
            rr_ptr_q   <= rr_ptr_d;
`endif
        end
    end

    always_ff @(posedge router_clk) begin
        if (router_srst_n && push_ok) begin
            fifo_mem[wr_ptr_q[LOG2_FIFO_DEPTH-1:0]] <= sel_flit;
        end
    end

    assign to_ingress_grant = grant_q;
    assign to_ingress_afull = afull_q;
    assign rdata            = rdata_q;
    assign rempty           = fifo_empty;
    assign rlevel           = level;
    assign overflow         = overflow_q;

endmodule

// File: tb/tb_hynoc_egress_port.sv
// Directed scoreboard bench for hynoc_egress_port; expectations follow HYNOC_EGRESS_PORT_FIXED_PRIO_EN if defined.
module tb_hynoc_egress_port;

    localparam int NB_PORTS   = 5;
    localparam int FLIT_WIDTH = 33;
    localparam int LOG2_DEPTH = 5;
    localparam int MARGIN     = 5;
    localparam int NS         = NB_PORTS - 1;
    localparam int DEPTH      = 2 ** LOG2_DEPTH;

    logic                         router_clk = 1'b0;
    logic                         router_srst_n;
    logic [NS-1:0]                from_ingress_request;
    logic [NS-1:0]                from_ingress_write;
    logic [NS*FLIT_WIDTH-1:0]     from_ingress_data;
    logic [NS-1:0]                to_ingress_grant;
    logic [NS-1:0]                to_ingress_afull;
    logic                         ren;
    logic [FLIT_WIDTH-1:0]        rdata;
    logic                         rempty;
    logic [LOG2_DEPTH:0]          rlevel;
    logic                         overflow;

    logic [FLIT_WIDTH-1:0]        slot [NS];
    logic [FLIT_WIDTH-1:0]        exp_q [$];
    int                           exp_level = 0;
    int                           vector_count = 0;
    int                           fail_count = 0;

    always #5 router_clk = ~router_clk;

    assign from_ingress_data = {slot[3], slot[2], slot[1], slot[0]};

    hynoc_egress_port #(
        .NB_PORTS        (NB_PORTS),
        .FLIT_WIDTH      (FLIT_WIDTH),
        .LOG2_FIFO_DEPTH (LOG2_DEPTH),
        .AFULL_MARGIN    (MARGIN)
    ) dut (
        .router_clk           (router_clk),
        .router_srst_n        (router_srst_n),
        .from_ingress_request (from_ingress_request),
        .from_ingress_write   (from_ingress_write),
        .from_ingress_data    (from_ingress_data),
        .to_ingress_grant     (to_ingress_grant),
        .to_ingress_afull     (to_ingress_afull),
        .ren                  (ren),
        .rdata                (rdata),
        .rempty               (rempty),
        .rlevel               (rlevel),
        .overflow             (overflow)
    );

    // Drive one cycle of inputs, then return just after the edge that consumed them.
    task automatic applyStimulus(input logic rst_n, input logic [NS-1:0] req, input logic [NS-1:0] wr,
                                 input int src, input logic [FLIT_WIDTH-1:0] flit, input logic rd);
        router_srst_n        = rst_n;
        from_ingress_request = req;
        from_ingress_write   = wr;
        ren                  = rd;
        for (int i = 0; i < NS; i++) begin
            slot[i] = (i == src) ? flit : {1'b1, 32'hBAD0_0000 + 32'(i)};
        end
        @(posedge router_clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        vector_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b0, '0, '0, 0, '0, 1'b0);
        exp_q.delete();
        exp_level = 0;
    endtask

    task automatic requestGrant(input string name, input logic [NS-1:0] req, input logic [NS-1:0] exp_grant);
        applyStimulus(1'b1, req, '0, 0, '0, 1'b0);
        checkOutput(name, 64'(to_ingress_grant), 64'(exp_grant));
    endtask

    task automatic writeOne(input int src, input logic [NS-1:0] req, input logic [FLIT_WIDTH-1:0] flit,
                            input logic [NS-1:0] noise);
        applyStimulus(1'b1, req, (NS'(1) << src) | noise, src, flit, 1'b0);
        if (exp_level < DEPTH) begin
            exp_q.push_back(flit);
            exp_level++;
        end
    endtask

    task automatic writePacket(input int src, input logic [NS-1:0] req, input int n, input logic [31:0] base);
        for (int k = 0; k < n; k++) begin
            writeOne(src, req, {(k == n - 1), base + 32'(k)}, '0);
        end
    endtask

    task automatic drain(input string name);
        while (exp_level > 0) begin
            applyStimulus(1'b1, '0, '0, 0, '0, 1'b1);
            exp_level--;
        end
        applyStimulus(1'b1, '0, '0, 0, '0, 1'b0);
        checkOutput({name, "_rempty"}, 64'(rempty), 64'd1);
        checkOutput({name, "_rlevel"}, 64'(rlevel), 64'd0);
        checkOutput({name, "_queue"}, 64'(exp_q.size()), 64'd0);
    endtask

    // Monitor: a read accepted in one cycle is compared against the scoreboard after the next edge.
    initial begin
        logic                  acc;
        logic [FLIT_WIDTH-1:0] e;
        forever begin
            @(negedge router_clk);
            acc = ren && !rempty && router_srst_n;
            @(posedge router_clk);
            #1;
            if (acc) begin
                vector_count++;
                if (exp_q.size() == 0) begin
                    fail_count++;
                    $display("[TB] FAIL rdata_unexpected: got %0h, expected no read data", rdata);
                end else begin
                    e = exp_q.pop_front();
                    if (rdata !== e) begin
                        fail_count++;
                        $display("[TB] FAIL rdata: got %0h, expected %0h", rdata, e);
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [NS-1:0] exp_g;
        int            src;

        for (int i = 0; i < NS; i++) slot[i] = '0;
        router_srst_n        = 1'b0;
        from_ingress_request = '0;
        from_ingress_write   = '0;
        ren                  = 1'b0;

        // Reset values
        doReset();
        doReset();
        checkOutput("rst_grant", 64'(to_ingress_grant), 64'd0);
        checkOutput("rst_afull", 64'(to_ingress_afull), 64'd0);
        checkOutput("rst_rempty", 64'(rempty), 64'd1);
        checkOutput("rst_rlevel", 64'(rlevel), 64'd0);
        checkOutput("rst_rdata", 64'(rdata), 64'd0);
        checkOutput("rst_overflow", 64'(overflow), 64'd0);

        // Single packet from ingress 2, with junk writes from ingress 0 that must be ignored
        $display("[TB] single packet");
        requestGrant("single_grant", 4'b0100, 4'b0100);
        writeOne(2, 4'b0100, {1'b0, 32'h0000_00A7}, 4'b0001);
        checkOutput("single_rempty_after_write", 64'(rempty), 64'd0);
        checkOutput("single_rlevel_1", 64'(rlevel), 64'd1);
        writeOne(2, 4'b0100, {1'b0, 32'h0000_00A8}, 4'b0001);
        writeOne(2, 4'b0100, {1'b0, 32'h0000_00A9}, 4'b0001);
        writeOne(2, 4'b0100, 33'h1_0000_00AA, 4'b0001);
        checkOutput("single_grant_released", 64'(to_ingress_grant), 64'd0);
        checkOutput("single_rlevel_4", 64'(rlevel), 64'd4);
        drain("single");

        // Contention between ingress 0 and 3; ingress 0 re-requests right after its packet
        $display("[TB] contention");
        doReset();
        requestGrant("cont_first", 4'b1001, 4'b0001);
        writePacket(0, 4'b1001, 2, 32'h0000_0100);
        checkOutput("cont_idle_gap", 64'(to_ingress_grant), 64'd0);
`ifdef HYNOC_EGRESS_PORT_FIXED_PRIO_EN
        exp_g = 4'b0001;
        src   = 0;
`else
        exp_g = 4'b1000;
        src   = 3;
`endif
        requestGrant("cont_second", 4'b1001, exp_g);
        writePacket(src, 4'b1001, 2, 32'h0000_0200);
        checkOutput("cont_second_released", 64'(to_ingress_grant), 64'd0);
        drain("cont");

        // All four request continuously with one-flit packets
        $display("[TB] round robin");
        doReset();
        for (int p = 0; p < 5; p++) begin
`ifdef HYNOC_EGRESS_PORT_FIXED_PRIO_EN
            src = 0;
`else
            src = p % NS;
`endif
            requestGrant($sformatf("rr_grant_%0d", p), 4'b1111, NS'(1) << src);
            writeOne(src, 4'b1111, {1'b1, 32'h0000_0300 + 32'(p)}, '0);
            checkOutput($sformatf("rr_release_%0d", p), 64'(to_ingress_grant), 64'd0);
        end
        drain("rr");

        // Backpressure: 30-flit packet from ingress 1, no reads
        $display("[TB] backpressure");
        doReset();
        requestGrant("bp_grant", 4'b0010, 4'b0010);
        for (int k = 1; k <= 30; k++) begin
            writeOne(1, 4'b0010, {(k == 30), 32'h0000_1000 + 32'(k)}, '0);
            checkOutput($sformatf("bp_rlevel_%0d", k), 64'(rlevel), 64'(k));
            checkOutput($sformatf("bp_afull_%0d", k), 64'(to_ingress_afull),
                        (k >= 28 && k < 30) ? 64'h2 : 64'h0);
        end
        drain("bp");

        // Overflow: 34-flit packet from ingress 3 ignoring afull, no reads
        $display("[TB] overflow");
        doReset();
        requestGrant("ovf_grant", 4'b1000, 4'b1000);
        for (int k = 1; k <= 34; k++) begin
            writeOne(3, 4'b1000, {(k == 34), 32'h0000_2000 + 32'(k)}, '0);
            if (k >= 32) begin
                checkOutput($sformatf("ovf_rlevel_%0d", k), 64'(rlevel), 64'd32);
                checkOutput($sformatf("ovf_flag_%0d", k), 64'(overflow), (k >= 33) ? 64'd1 : 64'd0);
            end
        end
        checkOutput("ovf_grant_released", 64'(to_ingress_grant), 64'd0);
        drain("ovf");
        checkOutput("ovf_sticky", 64'(overflow), 64'd1);

        // Reset mid-packet: ingress 0 sends 3 of 6 flits, then reset with a write in flight
        $display("[TB] reset mid-packet");
        requestGrant("midrst_grant", 4'b0001, 4'b0001);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 4'b0001, 4'b0001, 0, {1'b0, 32'h0000_3000 + 32'(k)}, 1'b0);
        end
        checkOutput("midrst_level_before", 64'(rlevel), 64'd3);
        applyStimulus(1'b0, 4'b0001, 4'b0001, 0, {1'b0, 32'h0000_3003}, 1'b0);
        exp_q.delete();
        exp_level = 0;
        checkOutput("midrst_grant", 64'(to_ingress_grant), 64'd0);
        checkOutput("midrst_rempty", 64'(rempty), 64'd1);
        checkOutput("midrst_rlevel", 64'(rlevel), 64'd0);
        checkOutput("midrst_overflow", 64'(overflow), 64'd0);
        checkOutput("midrst_rdata", 64'(rdata), 64'd0);
        requestGrant("post_rst_grant", 4'b0010, 4'b0010);
        writePacket(1, 4'b0010, 2, 32'h0000_4000);
        drain("post_rst");

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, fail_count);
        $finish;
    end

endmodule
